// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte channel between two packet requesters.
// A grant covers a whole packet and is followed by a programmable idle gap.
module uart_tx_arbiter #(
  parameter logic [7:0] GAP_CYCLES = 8'd16
) (
  input  logic       clk,
  input  logic       btn1,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [1:0] grant,
  output logic       busy
);

  localparam int unsigned DataW = 8;
  localparam int unsigned GrantW = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [GrantW-1:0]   grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [DataW-1:0]    gap_cnt_q, gap_cnt_d;
  logic                last_xfer;

  // State register; reset abandons any packet in flight
  always_ff @(posedge clk or negedge btn1) begin
    if (!btn1) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= 1'b1;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  // Next-state logic plus the combinational passthrough of the granted requester
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    gap_cnt_d    = gap_cnt_q;
    tx_data      = '0;
    tx_valid     = 1'b0;
    s0_ready     = 1'b0;
    s1_ready     = 1'b0;
    last_xfer    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s0_valid && s1_valid) begin
          grant_d = last_grant_q ? GrantW'(2'b01) : GrantW'(2'b10);
          state_d = ST_XFER;
        end else if (s0_valid) begin
          grant_d = GrantW'(2'b01);
          state_d = ST_XFER;
        end else if (s1_valid) begin
          grant_d = GrantW'(2'b10);
          state_d = ST_XFER;
        end
      end

      ST_XFER: begin
        if (grant_q[0]) begin
          tx_data   = s0_data;
          tx_valid  = s0_valid;
          s0_ready  = tx_ready;
          last_xfer = s0_valid & tx_ready & s0_last;
        end else if (grant_q[1]) begin
          tx_data   = s1_data;
          tx_valid  = s1_valid;
          s1_ready  = tx_ready;
          last_xfer = s1_valid & tx_ready & s1_last;
        end
        if (last_xfer) begin
          last_grant_d = grant_q[1];
          grant_d      = '0;
          if (GAP_CYCLES == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            gap_cnt_d = GAP_CYCLES - 8'd1;
            state_d   = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - DataW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one DUT with a 4-cycle gap, one with zero gap.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       btn1;
  logic [7:0] s0_data, s1_data, tx_data;
  logic       s0_valid, s0_last, s0_ready;
  logic       s1_valid, s1_last, s1_ready;
  logic       tx_valid, tx_ready, busy;
  logic [1:0] grant;

  logic [7:0] z_s0_data, z_s1_data, z_tx_data;
  logic       z_s0_valid, z_s0_last, z_s0_ready;
  logic       z_s1_valid, z_s1_last, z_s1_ready;
  logic       z_tx_valid, z_tx_ready, z_busy;
  logic [1:0] z_grant;

  int n_checks;
  int n_errors;

  uart_tx_arbiter #(.GAP_CYCLES(8'd4)) dut (
    .clk(clk), .btn1(btn1),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant), .busy(busy)
  );

  uart_tx_arbiter #(.GAP_CYCLES(8'd0)) dut_z (
    .clk(clk), .btn1(btn1),
    .s0_data(z_s0_data), .s0_valid(z_s0_valid), .s0_last(z_s0_last), .s0_ready(z_s0_ready),
    .s1_data(z_s1_data), .s1_valid(z_s1_valid), .s1_last(z_s1_last), .s1_ready(z_s1_ready),
    .tx_data(z_tx_data), .tx_valid(z_tx_valid), .tx_ready(z_tx_ready),
    .grant(z_grant), .busy(z_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant();
    for (int n = 0; n < 30 && grant == 2'b00; n++) cyc();
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 30 && busy; n++) cyc();
  endtask

  task automatic test_reset();
    #1;
    @(negedge clk);
    n_checks++;
    if ({tx_valid, tx_data, s0_ready, s1_ready, grant, busy} !== 14'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: got v=%b d=%h r0=%b r1=%b g=%b busy=%b want all 0",
               tx_valid, tx_data, s0_ready, s1_ready, grant, busy);
    end
    cyc();
    btn1 = 1'b1;
  endtask

  task automatic test_single();
    s0_data = 8'h41; s0_last = 1'b0; s0_valid = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (grant !== 2'b00) begin
      n_errors++; $display("FAIL single_idle_grant: got %b want 00", grant);
    end
    cyc();
    for (int i = 0; i < 3; i++) begin
      s0_data = 8'(8'h41 + i);
      s0_last = (i == 2);
      @(negedge clk);
      n_checks++;
      if ({grant, tx_valid, tx_data, s0_ready} !== {2'b01, 1'b1, 8'(8'h41 + i), 1'b1}) begin
        n_errors++;
        $display("FAIL single_byte%0d: got g=%b v=%b d=%h r=%b want g=01 v=1 d=%h r=1",
                 i, grant, tx_valid, tx_data, s0_ready, 8'(8'h41 + i));
      end
      cyc();
    end
    s0_valid = 1'b0; s0_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, grant, tx_valid} !== 4'b1000) begin
        n_errors++;
        $display("FAIL single_gap%0d: got busy=%b g=%b v=%b want busy=1 g=00 v=0",
                 i, busy, grant, tx_valid);
      end
      cyc();
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL single_gap_end: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_g [4];
    logic [7:0] exp_d;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    btn1 = 1'b0;
    cyc();
    btn1 = 1'b1;
    s0_data = 8'hA0; s0_last = 1'b1; s0_valid = 1'b1;
    s1_data = 8'hB0; s1_last = 1'b1; s1_valid = 1'b1;
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant();
      exp_d = exp_g[k][0] ? 8'hA0 : 8'hB0;
      @(negedge clk);
      n_checks++;
      if ({grant, tx_valid, tx_data, s1_ready, s0_ready} !== {exp_g[k], 1'b1, exp_d, exp_g[k]}) begin
        n_errors++;
        $display("FAIL tie_order%0d: got g=%b v=%b d=%h r1r0=%b%b want g=%b d=%h",
                 k, grant, tx_valid, tx_data, s1_ready, s0_ready, exp_g[k], exp_d);
      end
      cyc();
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_lock();
    s0_valid = 1'b0;
    s1_data = 8'hC1; s1_last = 1'b0; s1_valid = 1'b1;
    tx_ready = 1'b1;
    wait_grant();
    s0_data = 8'hD0; s0_last = 1'b1; s0_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({grant, tx_data} !== {2'b10, 8'hC1}) begin
      n_errors++; $display("FAIL lock_first: got g=%b d=%h want g=10 d=c1", grant, tx_data);
    end
    cyc();
    s1_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({grant, s0_ready, tx_valid} !== 4'b1000) begin
        n_errors++;
        $display("FAIL lock_hold%0d: got g=%b r0=%b v=%b want g=10 r0=0 v=0",
                 i, grant, s0_ready, tx_valid);
      end
      cyc();
    end
    s1_data = 8'hC2; s1_last = 1'b1; s1_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({grant, tx_data, s1_ready, s0_ready} !== {2'b10, 8'hC2, 2'b10}) begin
      n_errors++;
      $display("FAIL lock_resume: got g=%b d=%h r1=%b r0=%b want g=10 d=c2 r1=1 r0=0",
               grant, tx_data, s1_ready, s0_ready);
    end
    cyc();
    s1_valid = 1'b0; s1_last = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, grant} !== 3'b100) begin
      n_errors++; $display("FAIL lock_gap: got busy=%b g=%b want busy=1 g=00", busy, grant);
    end
    wait_grant();
    @(negedge clk);
    n_checks++;
    if ({grant, tx_data} !== {2'b01, 8'hD0}) begin
      n_errors++; $display("FAIL lock_s0_after: got g=%b d=%h want g=01 d=d0", grant, tx_data);
    end
    cyc();
    s0_valid = 1'b0; s0_last = 1'b0;
    wait_idle();
  endtask

  task automatic test_backpressure();
    logic pat [5];
    int idx;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    idx = 0;
    s0_data = 8'hE0; s0_last = 1'b0; s0_valid = 1'b1; tx_ready = 1'b1;
    wait_grant();
    for (int c = 0; c < 5; c++) begin
      tx_ready = pat[c];
      s0_data  = 8'(8'hE0 + idx);
      s0_last  = (idx == 2);
      @(negedge clk);
      n_checks++;
      if ({tx_valid, tx_data, s0_ready} !== {1'b1, 8'(8'hE0 + idx), pat[c]}) begin
        n_errors++;
        $display("FAIL bp_cycle%0d: got v=%b d=%h r0=%b want v=1 d=%h r0=%b",
                 c, tx_valid, tx_data, s0_ready, 8'(8'hE0 + idx), pat[c]);
      end
      cyc();
      if (pat[c]) idx++;
    end
    s0_valid = 1'b0; s0_last = 1'b0; tx_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, grant} !== 3'b100) begin
      n_errors++; $display("FAIL bp_done: got busy=%b g=%b want busy=1 g=00", busy, grant);
    end
    wait_idle();
  endtask

  task automatic test_zero_gap();
    z_s0_data = 8'h55; z_s0_last = 1'b1; z_s0_valid = 1'b1; z_tx_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (z_grant !== 2'b00) begin
      n_errors++; $display("FAIL zgap_idle: got g=%b want 00", z_grant);
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if ({z_grant, z_tx_valid, z_tx_data} !== {2'b01, 1'b1, 8'h55}) begin
      n_errors++; $display("FAIL zgap_pkt1: got g=%b v=%b d=%h want g=01 v=1 d=55",
                           z_grant, z_tx_valid, z_tx_data);
    end
    cyc();
    z_s0_data = 8'h56;
    @(negedge clk);
    n_checks++;
    if ({z_busy, z_grant, z_tx_valid} !== 4'b0000) begin
      n_errors++; $display("FAIL zgap_idle_after: got busy=%b g=%b v=%b want all 0",
                           z_busy, z_grant, z_tx_valid);
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if ({z_grant, z_tx_data} !== {2'b01, 8'h56}) begin
      n_errors++; $display("FAIL zgap_pkt2: got g=%b d=%h want g=01 d=56", z_grant, z_tx_data);
    end
    cyc();
    z_s0_valid = 1'b0; z_s0_last = 1'b0;
    @(negedge clk);
    n_checks++;
    if (z_busy !== 1'b0) begin
      n_errors++; $display("FAIL zgap_end: got busy=%b want 0", z_busy);
    end
  endtask

  task automatic test_reset_mid();
    s1_valid = 1'b0;
    s0_data = 8'hF0; s0_last = 1'b0; s0_valid = 1'b1; tx_ready = 1'b1;
    wait_grant();
    for (int i = 0; i < 2; i++) begin
      s0_data = 8'(8'hF0 + i);
      @(negedge clk);
      n_checks++;
      if (tx_data !== 8'(8'hF0 + i)) begin
        n_errors++; $display("FAIL rmid_byte%0d: got %h want %h", i, tx_data, 8'(8'hF0 + i));
      end
      cyc();
    end
    s0_data = 8'hF2;
    #2;
    btn1 = 1'b0;
    #1;
    n_checks++;
    if ({tx_valid, tx_data, grant, busy, s0_ready} !== 13'h0) begin
      n_errors++;
      $display("FAIL rmid_async: got v=%b d=%h g=%b busy=%b r0=%b want all 0",
               tx_valid, tx_data, grant, busy, s0_ready);
    end
    cyc();
    s0_data = 8'hF0;
    s1_data = 8'h99; s1_last = 1'b1; s1_valid = 1'b1;
    cyc();
    btn1 = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, grant} !== 3'b000) begin
      n_errors++; $display("FAIL rmid_release: got busy=%b g=%b want 0", busy, grant);
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if ({grant, tx_data} !== {2'b01, 8'hF0}) begin
      n_errors++; $display("FAIL rmid_tie_s0: got g=%b d=%h want g=01 d=f0", grant, tx_data);
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    cyc();
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    btn1 = 1'b0;
    s0_data = '0; s0_valid = 1'b0; s0_last = 1'b0;
    s1_data = '0; s1_valid = 1'b0; s1_last = 1'b0;
    tx_ready = 1'b0;
    z_s0_data = '0; z_s0_valid = 1'b0; z_s0_last = 1'b0;
    z_s1_data = '0; z_s1_valid = 1'b0; z_s1_last = 1'b0;
    z_tx_ready = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_lock();
    test_backpressure();
    test_zero_gap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
